rsa_decryptor: RTL and testbench
================================

Name: rsa_decryptor

Overview:
- Recovers plaintext M = C^d mod n from a WIDTH-bit ciphertext using the private exponent d.
- It is the receive-side counterpart of rsa_encryptor and uses the same start/done handshake style.
- The datapath is LSB-first square-and-multiply built on two iterative shift-add modular multipliers, so the block needs no hardware divider or wide multiplier.
- Latency is deterministic by default.

Parameters:
- WIDTH, 16, operand width of ciphertext, exponent, modulus and plaintext.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- ciphertext  in  WIDTH  C; latched when start is accepted.
- private_exp  in  WIDTH  d; latched when start is accepted.
- modulus  in  WIDTH  n; latched when start is accepted.
- plaintext  out  WIDTH  result; held until the next accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  invalid-operand flag; valid while done is high and held with plaintext.

Behaviour:
- Reset values: plaintext=0, busy=0, done=0, err=0; FSM in IDLE.
- Reset has immediate effect; reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, CHECK, MUL, STEP, FINISH.
- IDLE:
  - start=1: latch C, d, n; go to CHECK. Call this cycle 0.
  - start while busy is ignored. Inputs are don't-care after the latch.
- CHECK (cycle 1):
  - If n<2 or C>=n: err=1, plaintext=0, go to FINISH.
  - Otherwise: result=1, base=C, exp_sr=d, iter=0, go to MUL.
- MUL:
  - Pulse start to multiplier A (result*base) and multiplier B (base*base) on MUL entry.
  - Wait for both done flags. They arrive together, WIDTH cycles after the multiplier start.
- STEP (1 cycle):
  - result updates to A's product only if exp_sr[0]=1; base always updates to B's product.
  - exp_sr shifts right by 1; iter increments.
  - iter reaching WIDTH goes to FINISH, else back to MUL.
- FINISH:
  - plaintext=result (or 0 on error); done=1 for exactly one cycle; busy drops in the same cycle; return to IDLE.
  - A new start is accepted in the cycle after done.
- Latency, start cycle to done cycle:
  - Valid operands: WIDTH*(WIDTH+1)+2 cycles (274 for WIDTH=16).
  - Error: 2 cycles.
- Multiplier arithmetic (per cycle, MSB-first over b): acc = 2*acc; if acc>=n then acc -= n; if b[i] then acc += a; if acc>=n then acc -= n.
  - Intermediates are WIDTH+1 bits wide.
  - Requires a,b < n, which CHECK guarantees.
  - n up to 2^WIDTH-1 must not overflow.
- Boundaries:
  - d=0 gives plaintext 1.
  - C=0 with d>0 gives plaintext 0.
  - C=0 with d=0 gives plaintext 1.
  - d=1 gives plaintext C.

Optional Feature:
- Macro RSA_DEC_EARLY_EXIT_EN.
- Defined: STEP goes to FINISH as soon as the shifted exp_sr==0, and CHECK goes directly to FINISH when d==0 (plaintext 1, done at cycle 2).
  - Latency is (k+1)*(WIDTH+1)+2 cycles, where k is the index of d's MSB set bit.
- Undefined: fixed WIDTH iterations; latency is data-independent, which protects against timing side channels.
- Results are identical in both builds.

Decomposition:
- rsa_pkg holds:
  - the FSM state enum (IDLE, CHECK, MUL, STEP, FINISH);
  - the localparam RSA_WIDTH_DEFAULT=16;
  - the iteration-counter width function, $clog2(WIDTH+1).
- One sub-module, mod_mult (params: WIDTH).
  - Ports: clk, rst_n, start, a, b, n, product, done.
  - done pulses one cycle, WIDTH cycles after start.
  - Instantiated twice.

Test Plan:
- WIDTH=16, n=187, d=107, C=156: plaintext=7, err=0; done exactly 274 cycles after start (EARLY_EXIT build: 7*17+2=121).
- n=3233, d=2753, C=2790: plaintext=65; busy high throughout; done is a single-cycle pulse.
- n=187, d=1, C=100: plaintext=100. Then d=0: plaintext=1. Then C=0, d=5: plaintext=0.
- Error cases: n=1 gives err=1, plaintext=0, done at cycle 2. n=187, C=187 gives err=1.
- start re-pulsed at cycle 50 with other operands: ignored, and the original result is returned. Back-to-back start the cycle after done: accepted.
- rst_n low at cycle 100: outputs go to 0 immediately and no done pulse appears. A fresh start after release completes correctly.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA decryptor slice: FSM state
// encoding, default operand width and the iteration-counter width helper.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    STEP,
    FINISH
  } rsa_state_e;

  localparam int RSA_WIDTH_DEFAULT = 16;

  // Bits needed to count iterations 0..width inclusive.
  function automatic int rsa_iter_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rsa_decryptor_if.sv
// Request/response bundle between a requester and the RSA decryptor.
// The requester drives start and operands; the decryptor returns the
// plaintext together with busy/done/err status.
interface rsa_decryptor_if
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] ciphertext;
  logic [WIDTH-1:0] private_exp;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] plaintext;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, ciphertext, private_exp, modulus,
    input  plaintext, busy, done, err
  );

  modport slave (
    input  start, ciphertext, private_exp, modulus,
    output plaintext, busy, done, err
  );

endinterface

// File: rtl/rsa_decryptor_mod_mult.sv
// Iterative shift-add modular multiplier: product = a*b mod n, one bit of b
// per cycle, MSB first. The first bit is folded into the start cycle so the
// done pulse lands exactly WIDTH cycles after start with the product ready.
// Both operands must already be reduced below n.
module mod_mult #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_done;

  logic [WIDTH:0]   w_accIn;
  logic [WIDTH-1:0] w_aIn;
  logic [WIDTH-1:0] w_nIn;
  logic             w_bitIn;
  logic [WIDTH:0]   w_accNext;

  // One double-and-add step; the extra top bit keeps 2*acc and acc+a
  // from overflowing even when n is as large as 2^WIDTH-1.
  function automatic logic [WIDTH:0] mulStep(input logic [WIDTH:0]   acc,
                                             input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] nv,
                                             input logic             bi);
    logic [WIDTH:0] t;
    logic [WIDTH:0] nx;
    nx = {1'b0, nv};
    t  = {acc[WIDTH-1:0], 1'b0};
    if (t >= nx) t = t - nx;
    if (bi) t = t + {1'b0, av};
    if (t >= nx) t = t - nx;
    return t;
  endfunction

  // On start the step uses fresh operands from the ports with a zero
  // accumulator; afterwards it runs on the captured copies.
  always_comb begin
    w_accIn   = r_acc;
    w_aIn     = r_a;
    w_nIn     = r_n;
    w_bitIn   = r_b[WIDTH-1];
    if (start) begin
      w_accIn = '0;
      w_aIn   = a;
      w_nIn   = n;
      w_bitIn = b[WIDTH-1];
    end
    w_accNext = mulStep(w_accIn, w_aIn, w_nIn, w_bitIn);
  end

  // Accumulator, operand capture and bit counter; done is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_n    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_acc  <= w_accNext;
        r_a    <= a;
        r_b    <= b << 1;
        r_n    <= n;
        r_cnt  <= CW'(WIDTH - 1);
        r_run  <= (WIDTH > 1);
        r_done <= (WIDTH == 1);
      end else if (r_run) begin
        r_acc <= w_accNext;
        r_b   <= r_b << 1;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign product = r_acc[WIDTH-1:0];
  assign done    = r_done;

endmodule

// File: rtl/rsa_decryptor.sv
// RSA decryptor: plaintext = C^d mod n using LSB-first square-and-multiply
// on two shift-add modular multipliers running in parallel (result*base and
// base*base). By default every request runs WIDTH iterations so latency does
// not depend on the exponent. Defining RSA_DEC_EARLY_EXIT_EN stops as soon
// as the remaining exponent bits are all zero (and skips work for d==0).
module rsa_decryptor
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  rsa_decryptor_if.slave bus
);

  localparam int ITW = rsa_iter_width(WIDTH);

  rsa_state_e       r_state;
  rsa_state_e       w_nextState;

  logic [WIDTH-1:0] r_cipher;
  logic [WIDTH-1:0] r_mod;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_base;
  logic [ITW-1:0]   r_iter;
  logic [WIDTH-1:0] r_plaintext;
  logic             r_err;

  logic [WIDTH-1:0] w_cipherNext;
  logic [WIDTH-1:0] w_modNext;
  logic [WIDTH-1:0] w_expNext;
  logic [WIDTH-1:0] w_resultNext;
  logic [WIDTH-1:0] w_baseNext;
  logic [ITW-1:0]   w_iterNext;
  logic [WIDTH-1:0] w_ptNext;
  logic             w_errNext;

  logic             w_mulStart;
  logic [WIDTH-1:0] w_prodA;
  logic [WIDTH-1:0] w_prodB;
  logic             w_doneA;
  logic             w_doneB;
  logic             w_lastIter;

  // Next-state and datapath updates; multipliers are fed the next
  // result/base so they can start on the same edge that enters MUL.
  always_comb begin
    w_nextState  = r_state;
    w_cipherNext = r_cipher;
    w_modNext    = r_mod;
    w_expNext    = r_exp;
    w_resultNext = r_result;
    w_baseNext   = r_base;
    w_iterNext   = r_iter;
    w_ptNext     = r_plaintext;
    w_errNext    = r_err;
    w_lastIter   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_cipherNext = bus.ciphertext;
          w_expNext    = bus.private_exp;
          w_modNext    = bus.modulus;
          w_nextState  = CHECK;
        end
      end
      CHECK: begin
        if ((r_mod < WIDTH'(2)) || (r_cipher >= r_mod)) begin
          w_errNext   = 1'b1;
          w_ptNext    = '0;
          w_nextState = FINISH;
`ifdef RSA_DEC_EARLY_EXIT_EN
        end else if (r_exp == '0) begin
          w_errNext   = 1'b0;
          w_ptNext    = WIDTH'(1);
          w_nextState = FINISH;
`endif
        end else begin
          w_resultNext = WIDTH'(1);
          w_baseNext   = r_cipher;
          w_iterNext   = '0;
          w_nextState  = MUL;
        end
      end
      MUL: begin
        if (w_doneA && w_doneB) w_nextState = STEP;
      end
      STEP: begin
        if (r_exp[0]) w_resultNext = w_prodA;
        w_baseNext = w_prodB;
        w_expNext  = r_exp >> 1;
        w_iterNext = r_iter + 1'b1;
`ifdef RSA_DEC_EARLY_EXIT_EN
        w_lastIter = (w_iterNext == ITW'(WIDTH)) || (w_expNext == '0);
`else
        w_lastIter = (w_iterNext == ITW'(WIDTH));
`endif
        if (w_lastIter) begin
          w_ptNext    = w_resultNext;
          w_errNext   = 1'b0;
          w_nextState = FINISH;
        end else begin
          w_nextState = MUL;
        end
      end
      FINISH: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    w_mulStart = (w_nextState == MUL) && (r_state != MUL);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cipher    <= '0;
      r_mod       <= '0;
      r_exp       <= '0;
      r_result    <= '0;
      r_base      <= '0;
      r_iter      <= '0;
      r_plaintext <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cipher    <= w_cipherNext;
      r_mod       <= w_modNext;
      r_exp       <= w_expNext;
      r_result    <= w_resultNext;
      r_base      <= w_baseNext;
      r_iter      <= w_iterNext;
      r_plaintext <= w_ptNext;
      r_err       <= w_errNext;
    end
  end

  mod_mult #(.WIDTH(WIDTH)) u_multA (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mulStart),
    .a       (w_resultNext),
    .b       (w_baseNext),
    .n       (r_mod),
    .product (w_prodA),
    .done    (w_doneA)
  );

  mod_mult #(.WIDTH(WIDTH)) u_multB (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mulStart),
    .a       (w_baseNext),
    .b       (w_baseNext),
    .n       (r_mod),
    .product (w_prodB),
    .done    (w_doneB)
  );

  assign bus.plaintext = r_plaintext;
  assign bus.err       = r_err;
  assign bus.done      = (r_state == FINISH);
  assign bus.busy      = (r_state == CHECK) || (r_state == MUL) || (r_state == STEP);

endmodule

// File: tb/tb_rsa_decryptor.sv
// Scoreboard bench for rsa_decryptor: expected results come from a plain
// multiply/modulo reference and a latency formula, queued at request time
// and popped when done is seen.
module tb_rsa_decryptor;
  import rsa_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] pt;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rsa_decryptor_if #(.WIDTH(W)) bus ();

  rsa_decryptor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic modelErr(input logic [W-1:0] c, input logic [W-1:0] n);
    return (n < 2) || (c >= n);
  endfunction

  function automatic logic [W-1:0] modelExp(input logic [W-1:0] c, input logic [W-1:0] d,
                                            input logic [W-1:0] n);
    longint r, b, m;
    if (modelErr(c, n)) return '0;
    m = longint'(n);
    r = 1;
    b = longint'(c);
    for (int i = 0; i < W; i++) begin
      if (d[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic int modelLat(input logic [W-1:0] c, input logic [W-1:0] d,
                                  input logic [W-1:0] n);
    int k;
    if (modelErr(c, n)) return 2;
`ifdef RSA_DEC_EARLY_EXIT_EN
    if (d == 0) return 2;
    k = 0;
    for (int i = 0; i < W; i++) if (d[i]) k = i;
    return (k + 1) * (W + 1) + 2;
`else
    k = W;
    return k * (W + 1) + 2;
`endif
  endfunction

  function automatic exp_t mkExp(input logic [W-1:0] c, input logic [W-1:0] d,
                                 input logic [W-1:0] n);
    exp_t e;
    e.pt  = modelExp(c, d, n);
    e.err = modelErr(c, n);
    e.lat = modelLat(c, d, n);
    return e;
  endfunction

  // Drives one request (caller sits at a negedge) and watches for done.
  // Optionally re-pulses start with other operands at cycle reCycle.
  task automatic applyStimulus(input logic [W-1:0] c, input logic [W-1:0] d,
                               input logic [W-1:0] n, input int reCycle,
                               output logic [W-1:0] pt, output logic err, output int lat,
                               output int busyBad, output logic doneAfter,
                               output logic timedOut);
    bus.ciphertext  = c;
    bus.private_exp = d;
    bus.modulus     = n;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start       = 1'b0;
    bus.ciphertext  = W'($urandom);
    bus.private_exp = W'($urandom);
    bus.modulus     = W'($urandom);
    pt = '0; err = 1'b0; lat = 0; busyBad = 0; doneAfter = 1'b0; timedOut = 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == reCycle) begin
        bus.start       = 1'b1;
        bus.ciphertext  = 16'd2790;
        bus.private_exp = 16'd2753;
        bus.modulus     = 16'd3233;
      end else if (cyc == reCycle + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat = cyc;
        pt  = bus.plaintext;
        err = bus.err;
        if (bus.busy !== 1'b0) busyBad++;
        timedOut = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busyBad++;
    end
    bus.start = 1'b0;
    @(negedge clk);
    doneAfter = bus.done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.ciphertext = '0;
    bus.private_exp = '0;
    bus.modulus = '0;
    #1;
    compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    compared++; if (bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
    compared++; if (bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 0", bus.err); end
    compared++; if (bus.plaintext !== '0) begin mismatched++; $display("[TB] FAIL reset_plaintext: got %0d want 0", bus.plaintext); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_after_reset: busy %b done %b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_basic();
    logic [W-1:0] pt; logic err, da, to; int lat, bb;
    exp_t e;
    @(negedge clk);
    sbQ.push_back(mkExp(16'd156, 16'd107, 16'd187));
    applyStimulus(16'd156, 16'd107, 16'd187, -1, pt, err, lat, bb, da, to);
    e = sbQ.pop_front();
    compared++; if (to !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_timeout: no done within bound"); end
    compared++; if (pt !== e.pt) begin mismatched++; $display("[TB] FAIL basic_plaintext: got %0d want %0d", pt, e.pt); end
    compared++; if (err !== e.err) begin mismatched++; $display("[TB] FAIL basic_err: got %b want %b", err, e.err); end
    compared++; if (lat != e.lat) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_classic();
    logic [W-1:0] pt; logic err, da, to; int lat, bb;
    exp_t e;
    sbQ.push_back(mkExp(16'd2790, 16'd2753, 16'd3233));
    applyStimulus(16'd2790, 16'd2753, 16'd3233, -1, pt, err, lat, bb, da, to);
    e = sbQ.pop_front();
    compared++; if (pt !== e.pt || to !== 1'b0) begin mismatched++; $display("[TB] FAIL classic_plaintext: got %0d want %0d (timeout %b)", pt, e.pt, to); end
    compared++; if (lat != e.lat) begin mismatched++; $display("[TB] FAIL classic_latency: got %0d want %0d", lat, e.lat); end
    compared++; if (bb != 0) begin mismatched++; $display("[TB] FAIL classic_busy: %0d bad busy cycles want 0", bb); end
    compared++; if (da !== 1'b0) begin mismatched++; $display("[TB] FAIL classic_single_pulse: done after pulse %b want 0", da); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] cs[4] = '{16'd100, 16'd100, 16'd0, 16'd0};
    logic [W-1:0] ds[4] = '{16'd1, 16'd0, 16'd5, 16'd0};
    logic [W-1:0] pt; logic err, da, to; int lat, bb;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sbQ.push_back(mkExp(cs[i], ds[i], 16'd187));
      applyStimulus(cs[i], ds[i], 16'd187, -1, pt, err, lat, bb, da, to);
      e = sbQ.pop_front();
      compared++; if (pt !== e.pt || to !== 1'b0) begin mismatched++; $display("[TB] FAIL boundary%0d_plaintext: got %0d want %0d (timeout %b)", i, pt, e.pt, to); end
      compared++; if (err !== e.err) begin mismatched++; $display("[TB] FAIL boundary%0d_err: got %b want %b", i, err, e.err); end
      compared++; if (lat != e.lat) begin mismatched++; $display("[TB] FAIL boundary%0d_latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_errors();
    logic [W-1:0] cs[2] = '{16'd0, 16'd187};
    logic [W-1:0] ns[2] = '{16'd1, 16'd187};
    logic [W-1:0] pt; logic err, da, to; int lat, bb;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sbQ.push_back(mkExp(cs[i], 16'd107, ns[i]));
      applyStimulus(cs[i], 16'd107, ns[i], -1, pt, err, lat, bb, da, to);
      e = sbQ.pop_front();
      compared++; if (err !== e.err || to !== 1'b0) begin mismatched++; $display("[TB] FAIL error%0d_err: got %b want %b (timeout %b)", i, err, e.err, to); end
      compared++; if (pt !== e.pt) begin mismatched++; $display("[TB] FAIL error%0d_plaintext: got %0d want %0d", i, pt, e.pt); end
      compared++; if (lat != e.lat) begin mismatched++; $display("[TB] FAIL error%0d_latency: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] pt; logic err, da, to; int lat, bb;
    exp_t e;
    sbQ.push_back(mkExp(16'd156, 16'd107, 16'd187));
    applyStimulus(16'd156, 16'd107, 16'd187, 50, pt, err, lat, bb, da, to);
    e = sbQ.pop_front();
    compared++; if (pt !== e.pt || to !== 1'b0) begin mismatched++; $display("[TB] FAIL ignore_plaintext: got %0d want %0d (timeout %b)", pt, e.pt, to); end
    compared++; if (lat != e.lat) begin mismatched++; $display("[TB] FAIL ignore_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pt; logic err, da, to; int lat, bb;
    exp_t e;
    sbQ.push_back(mkExp(16'd100, 16'd1, 16'd187));
    applyStimulus(16'd100, 16'd1, 16'd187, -1, pt, err, lat, bb, da, to);
    e = sbQ.pop_front();
    compared++; if (pt !== e.pt || to !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_first: got %0d want %0d (timeout %b)", pt, e.pt, to); end
    sbQ.push_back(mkExp(16'd156, 16'd107, 16'd187));
    applyStimulus(16'd156, 16'd107, 16'd187, -1, pt, err, lat, bb, da, to);
    e = sbQ.pop_front();
    compared++; if (pt !== e.pt || to !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_second: got %0d want %0d (timeout %b)", pt, e.pt, to); end
    compared++; if (lat != e.lat) begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] pt; logic err, da, to; int lat, bb, doneSeen;
    exp_t e;
    bus.ciphertext  = 16'd2790;
    bus.private_exp = 16'd2753;
    bus.modulus     = 16'd3233;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    doneSeen = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
    end
    rst_n = 1'b0;
    #1;
    compared++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_status: busy %b done %b want 0 0", bus.busy, bus.done); end
    compared++; if (bus.plaintext !== '0 || bus.err !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_outputs: plaintext %0d err %b want 0 0", bus.plaintext, bus.err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
    end
    compared++; if (doneSeen != 0) begin mismatched++; $display("[TB] FAIL midreset_no_done: got %0d done pulses want 0", doneSeen); end
    sbQ.push_back(mkExp(16'd156, 16'd107, 16'd187));
    applyStimulus(16'd156, 16'd107, 16'd187, -1, pt, err, lat, bb, da, to);
    e = sbQ.pop_front();
    compared++; if (pt !== e.pt || to !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_fresh: got %0d want %0d (timeout %b)", pt, e.pt, to); end
    compared++; if (lat != e.lat) begin mismatched++; $display("[TB] FAIL midreset_latency: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic checkOutput();
    compared++; if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL scoreboard_drain: %0d entries left want 0", sbQ.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_classic();
    test_boundaries();
    test_errors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    checkOutput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
